// File: rtl/cpu_pkg.sv
// Shared pipeline types for the integer datapath.
// Register ids and data words are declared here so the pipeline registers and the register file agree on them.
package cpu_pkg;

   localparam int XLEN     = 32;
   localparam int REG_ID_W = 5;

   typedef logic [REG_ID_W-1:0] reg_id_t;
   typedef logic [XLEN-1:0]     word_t;

   localparam reg_id_t REG_ZERO = 5'd0;

endpackage

// File: rtl/wb_bypass_mux.sv
// Operand select for one ID-stage read port.
// The priority is: the hardwired zero register, then the in-flight writeback, then the stored register.
module wb_bypass_mux
   import cpu_pkg::*;
#(
   parameter int XLEN     = 32,
   parameter bit ZERO_REG = 1'b1
) (
   input  reg_id_t           rs_id,
   input  logic              wb_we,
   input  reg_id_t           wb_rdst_id,
   input  logic [XLEN-1:0]   wb_rdata,
   input  logic [XLEN-1:0]   arr_rdata,
   output logic [XLEN-1:0]   rs_data
);

   always_comb begin
      // NOTE: the default comes first, so every path assigns rs_data and no latch is inferred.
      rs_data = arr_rdata;
      if (ZERO_REG && (rs_id == REG_ZERO)) begin
         rs_data = '0;
      end else if (wb_we && (wb_rdst_id == rs_id)) begin
         rs_data = wb_rdata;
      end
   end

endmodule

// File: rtl/wb_regfile.sv
// Architectural register file at the writeback end of the pipeline.
// Reads are asynchronous, with a same-cycle write-through bypass on the two ID-stage ports.
module wb_regfile
   import cpu_pkg::*;
#(
   parameter int XLEN     = 32,
   parameter int NREG     = 32,
   parameter bit ZERO_REG = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wb_we_reg,
   input  reg_id_t           wb_rdst_id,
   input  logic [XLEN-1:0]   wb_rdata,
   input  reg_id_t           id_rs1_id,
   input  reg_id_t           id_rs2_id,
   output logic [XLEN-1:0]   id_rs1_data,
   output logic [XLEN-1:0]   id_rs2_data,
   input  reg_id_t           dbg_rid,
   output logic [XLEN-1:0]   dbg_rdata,
   output logic [31:0]       wr_count
);

   localparam int IDX_W = $clog2(NREG);

   logic [XLEN-1:0] regs [NREG];
   logic [31:0]     wr_count_q;
   logic            commit;
   logic [XLEN-1:0] arr_rs1;
   logic [XLEN-1:0] arr_rs2;

   // A write to x0 is dropped entirely, so it does not count as retired either.
   assign commit = wb_we_reg && !(ZERO_REG && (wb_rdst_id == REG_ZERO));

   always_ff @(posedge clk) begin
      if (!rst) begin
         // NOTE: the array is cleared on reset so that no read index can ever return X.
         for (int i = 0; i < NREG; i++) begin
            regs[i] <= '0;
         end
         // NOTE: sequential state uses non-blocking assignments, so every reader sees the pre-edge value.
         wr_count_q <= '0;
      end else if (commit) begin
         regs[wb_rdst_id[IDX_W-1:0]] <= wb_rdata;
         wr_count_q                  <= wr_count_q + 32'd1;
      end
   end

   assign arr_rs1  = regs[id_rs1_id[IDX_W-1:0]];
   assign arr_rs2  = regs[id_rs2_id[IDX_W-1:0]];
   assign wr_count = wr_count_q;

   // The debug port shows committed state only and never sees the bypass.
   assign dbg_rdata = (ZERO_REG && (dbg_rid == REG_ZERO)) ? '0 : regs[dbg_rid[IDX_W-1:0]];

   wb_bypass_mux #(
      .XLEN     (XLEN),
      .ZERO_REG (ZERO_REG)
   ) u_rs1_mux (
      .rs_id      (id_rs1_id),
      .wb_we      (wb_we_reg),
      .wb_rdst_id (wb_rdst_id),
      .wb_rdata   (wb_rdata),
      .arr_rdata  (arr_rs1),
      .rs_data    (id_rs1_data)
   );

   wb_bypass_mux #(
      .XLEN     (XLEN),
      .ZERO_REG (ZERO_REG)
   ) u_rs2_mux (
      .rs_id      (id_rs2_id),
      .wb_we      (wb_we_reg),
      .wb_rdst_id (wb_rdst_id),
      .wb_rdata   (wb_rdata),
      .arr_rdata  (arr_rs2),
      .rs_data    (id_rs2_data)
   );

endmodule
